// File: rtl/pa_window_counter.sv
// Parallel counter for N stochastic bitstream lanes. It counts ones per beat, sums them
// over LEN accepted beats, and emits the window total in unipolar or bipolar form.
module pa_window_counter #(
    parameter  int unsigned N     = 8,
    parameter  int unsigned LEN   = 256,
    localparam int unsigned PC_W  = $clog2(N + 1),
    localparam int unsigned ACC_W = $clog2(N * LEN + 1),
    localparam int unsigned RES_W = ACC_W + 1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             clear,
    input  logic             in_valid,
    input  logic [N-1:0]     data_in,
    input  logic             bipolar,
    output logic             out_valid,
    output logic [RES_W-1:0] result,
    output logic             busy
);

    localparam int unsigned BEAT_W = $clog2(LEN);
    localparam int unsigned NL     = N * LEN;

    typedef enum logic {
        S_IDLE = 1'b0,
        S_ACC  = 1'b1
    } state_t;

    state_t            r_state;
    logic              r_pc_v;
    logic [PC_W-1:0]   r_pc_q;
    logic [ACC_W-1:0]  r_acc;
    logic [BEAT_W-1:0] r_beats;
    logic              r_out_valid;
    logic [RES_W-1:0]  r_result;

    logic [PC_W-1:0]   w_pc;
    logic [ACC_W-1:0]  w_sum;
    logic [RES_W-1:0]  w_uni;
    logic [RES_W-1:0]  w_bip;
    logic              w_last;

    // Ones count across all lanes of the incoming beat.
    always_comb begin
        w_pc = '0;
        for (int i = 0; i < N; i++) begin
            w_pc = w_pc + PC_W'(data_in[i]);
        end
    end

    // Bipolar value is 2*sum - N*LEN, computed modulo 2^RES_W so it reads as signed.
    assign w_sum  = r_acc + ACC_W'(r_pc_q);
    assign w_uni  = RES_W'(w_sum);
    assign w_bip  = (w_uni << 1) - RES_W'(NL);
    assign w_last = (r_state == S_ACC) && (r_beats == BEAT_W'(LEN - 1));

    // Stage 1: register the per-beat popcount.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_pc_v <= 1'b0;
            r_pc_q <= '0;
        end else if (clear) begin
            r_pc_v <= 1'b0;
        end else begin
            r_pc_v <= in_valid;
            if (in_valid) begin
                r_pc_q <= w_pc;
            end
        end
    end

    // Stage 2: window accumulation and result generation.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= S_IDLE;
            r_acc       <= '0;
            r_beats     <= '0;
            r_out_valid <= 1'b0;
            r_result    <= '0;
        end else begin
            r_out_valid <= 1'b0;
            if (clear) begin
                r_state <= S_IDLE;
                r_acc   <= '0;
                r_beats <= '0;
            end else if (r_pc_v) begin
                case (r_state)
                    S_IDLE: begin
                        r_acc   <= ACC_W'(r_pc_q);
                        r_beats <= BEAT_W'(1);
                        r_state <= S_ACC;
                    end
                    S_ACC: begin
                        if (w_last) begin
                            r_result    <= bipolar ? w_bip : w_uni;
                            r_out_valid <= 1'b1;
                            r_acc       <= '0;
                            r_beats     <= '0;
                            r_state     <= S_IDLE;
                        end else begin
                            r_acc   <= w_sum;
                            r_beats <= r_beats + BEAT_W'(1);
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign out_valid = r_out_valid;
    assign result    = r_result;
    assign busy      = r_pc_v || (r_state == S_ACC);

endmodule

// File: tb/tb_pa_window_counter.sv
// Bench for pa_window_counter (N=8, LEN=4): directed and random windows checked
// every cycle against a window-level reference model.
module tb_pa_window_counter;

    localparam int unsigned N     = 8;
    localparam int unsigned LEN   = 4;
    localparam int unsigned RES_W = 7;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             clear = 1'b0;
    logic             in_valid = 1'b0;
    logic [N-1:0]     data_in = '0;
    logic             bipolar = 1'b0;
    logic             out_valid;
    logic [RES_W-1:0] result;
    logic             busy;

    int total = 0;
    int bad   = 0;

    // Reference model state: beats/sum of the open window, plus a completed window
    // whose result is due at the next clock edge.
    int               win_cnt  = 0;
    int               win_sum  = 0;
    bit               pend     = 0;
    int               pend_sum = 0;
    logic             exp_ov   = 1'b0;
    logic [RES_W-1:0] exp_res  = '0;
    logic             exp_busy = 1'b0;
    int               cyc      = 0;

    pa_window_counter #(.N(N), .LEN(LEN)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .clear    (clear),
        .in_valid (in_valid),
        .data_in  (data_in),
        .bipolar  (bipolar),
        .out_valid(out_valid),
        .result   (result),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    // Drive one cycle and advance the model; outputs settle #1 after the edge.
    task automatic step(input logic v, input logic [N-1:0] d, input logic clr, input logic bp);
        int s;
        @(negedge clk);
        in_valid = v;
        data_in  = d;
        clear    = clr;
        bipolar  = bp;
        @(posedge clk);
        cyc++;
        exp_ov = 1'b0;
        if (pend && !clr) begin
            exp_ov = 1'b1;
            s = bp ? (2 * pend_sum - int'(N * LEN)) : pend_sum;
            exp_res = RES_W'(s);
        end
        pend = 0;
        if (clr) begin
            win_cnt = 0;
            win_sum = 0;
        end else if (v) begin
            win_sum += $countones(d);
            win_cnt++;
            if (win_cnt == int'(LEN)) begin
                pend     = 1;
                pend_sum = win_sum;
                win_cnt  = 0;
                win_sum  = 0;
            end
        end
        exp_busy = (win_cnt > 0) || pend;
        #1;
    endtask

    task automatic idle(input logic bp);
        step(1'b0, '0, 1'b0, bp);
    endtask

    task automatic test_reset();
        total++;
        if ({out_valid, result, busy} !== {1'b0, 7'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset: got ov=%b res=%h busy=%b want ov=0 res=00 busy=0", out_valid, result, busy);
        end
    endtask

    task automatic test_full_window(input logic [N-1:0] d, input logic bp, input logic [RES_W-1:0] want);
        int pulses = 0;
        for (int i = 0; i < 7; i++) begin
            if (i < 4) step(1'b1, d, 1'b0, bp);
            else idle(bp);
            if (out_valid) pulses++;
            total++;
            if ({out_valid, result, busy} !== {exp_ov, exp_res, exp_busy}) begin
                bad++;
                $display("FAIL window d=%h bp=%b step %0d: got ov=%b res=%h busy=%b want ov=%b res=%h busy=%b",
                         d, bp, i, out_valid, result, busy, exp_ov, exp_res, exp_busy);
            end
        end
        total++;
        if (pulses != 1 || result !== want) begin
            bad++;
            $display("FAIL window_total d=%h bp=%b: got pulses=%0d res=%h want pulses=1 res=%h",
                     d, bp, pulses, result, want);
        end
    endtask

    task automatic test_gaps(input logic bp, input logic [RES_W-1:0] want);
        logic [1:0] pat [12] = '{1, 1, 0, 1, 0, 0, 0, 1, 0, 0, 0, 2};
        int pulses = 0;
        for (int i = 0; i < 12; i++) begin
            if (pat[i] == 2'd1) step(1'b1, 8'h0F, 1'b0, bp);
            else idle(bp);
            if (out_valid) pulses++;
            total++;
            if ({out_valid, result, busy} !== {exp_ov, exp_res, exp_busy}) begin
                bad++;
                $display("FAIL gaps bp=%b step %0d: got ov=%b res=%h busy=%b want ov=%b res=%h busy=%b",
                         bp, i, out_valid, result, busy, exp_ov, exp_res, exp_busy);
            end
            if (i >= 1 && i <= 7) begin
                total++;
                if (busy !== 1'b1) begin
                    bad++;
                    $display("FAIL gaps_busy bp=%b step %0d: got busy=%b want 1", bp, i, busy);
                end
            end
        end
        total++;
        if (pulses != 1 || result !== want) begin
            bad++;
            $display("FAIL gaps_total bp=%b: got pulses=%0d res=%h want pulses=1 res=%h", bp, pulses, result, want);
        end
    endtask

    task automatic test_back_to_back();
        int p_cyc [$];
        logic [RES_W-1:0] p_res [$];
        for (int i = 0; i < 11; i++) begin
            if (i < 4) step(1'b1, 8'h01, 1'b0, 1'b0);
            else if (i < 8) step(1'b1, 8'h03, 1'b0, 1'b0);
            else idle(1'b0);
            if (out_valid) begin
                p_cyc.push_back(cyc);
                p_res.push_back(result);
            end
            total++;
            if ({out_valid, result, busy} !== {exp_ov, exp_res, exp_busy}) begin
                bad++;
                $display("FAIL b2b step %0d: got ov=%b res=%h busy=%b want ov=%b res=%h busy=%b",
                         i, out_valid, result, busy, exp_ov, exp_res, exp_busy);
            end
        end
        total++;
        if (p_cyc.size() != 2) begin
            bad++;
            $display("FAIL b2b_pulses: got %0d pulses want 2", p_cyc.size());
        end else if (p_cyc[1] - p_cyc[0] != 4 || p_res[0] !== 7'd4 || p_res[1] !== 7'd8) begin
            bad++;
            $display("FAIL b2b_spacing: got gap=%0d res=%h,%h want gap=4 res=04,08",
                     p_cyc[1] - p_cyc[0], p_res[0], p_res[1]);
        end
    endtask

    task automatic test_clear();
        // v, clr, data: two beats, abort, fresh window; then abort on the final-beat stage.
        logic [9:0] seq [16] = '{
            {2'b10, 8'hFF}, {2'b10, 8'hFF}, {2'b01, 8'h00},
            {2'b10, 8'h01}, {2'b10, 8'h01}, {2'b10, 8'h01}, {2'b10, 8'h01},
            {2'b00, 8'h00}, {2'b00, 8'h00}, {2'b00, 8'h00},
            {2'b10, 8'h07}, {2'b10, 8'h07}, {2'b10, 8'h07}, {2'b10, 8'h07},
            {2'b01, 8'h00}, {2'b00, 8'h00}};
        int pulses = 0;
        for (int i = 0; i < 16; i++) begin
            step(seq[i][9], seq[i][7:0], seq[i][8], 1'b0);
            if (out_valid) pulses++;
            total++;
            if ({out_valid, result, busy} !== {exp_ov, exp_res, exp_busy}) begin
                bad++;
                $display("FAIL clear step %0d: got ov=%b res=%h busy=%b want ov=%b res=%h busy=%b",
                         i, out_valid, result, busy, exp_ov, exp_res, exp_busy);
            end
        end
        total++;
        if (pulses != 1 || result !== 7'd4 || busy !== 1'b0) begin
            bad++;
            $display("FAIL clear_total: got pulses=%0d res=%h busy=%b want pulses=1 res=04 busy=0",
                     pulses, result, busy);
        end
    endtask

    task automatic test_reset_mid();
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        step(1'b1, 8'hFF, 1'b0, 1'b0);
        @(negedge clk);
        in_valid = 1'b0;
        #2 rst_n = 1'b0;
        win_cnt = 0; win_sum = 0; pend = 0;
        exp_ov = 1'b0; exp_res = '0; exp_busy = 1'b0;
        #1;
        total++;
        if ({out_valid, result, busy} !== {1'b0, 7'd0, 1'b0}) begin
            bad++;
            $display("FAIL reset_mid: got ov=%b res=%h busy=%b want ov=0 res=00 busy=0", out_valid, result, busy);
        end
        @(posedge clk);
        #3 rst_n = 1'b1;
        for (int i = 0; i < 7; i++) begin
            if (i < 4) step(1'b1, 8'h01, 1'b0, 1'b0);
            else idle(1'b0);
            total++;
            if ({out_valid, result, busy} !== {exp_ov, exp_res, exp_busy}) begin
                bad++;
                $display("FAIL reset_mid step %0d: got ov=%b res=%h busy=%b want ov=%b res=%h busy=%b",
                         i, out_valid, result, busy, exp_ov, exp_res, exp_busy);
            end
        end
        total++;
        if (result !== 7'd4) begin
            bad++;
            $display("FAIL reset_mid_total: got res=%h want 04", result);
        end
    endtask

    task automatic test_random();
        logic bp = 1'b0;
        logic v, clr;
        logic [N-1:0] d;
        int pulses = 0;
        for (int i = 0; i < 400; i++) begin
            if (win_cnt == 0 && !pend) bp = 1'($urandom_range(0, 1));
            v   = ($urandom_range(0, 3) != 0);
            clr = ($urandom_range(0, 24) == 0);
            d   = N'($urandom);
            step(v, d, clr, bp);
            if (out_valid) pulses++;
            total++;
            if ({out_valid, result, busy} !== {exp_ov, exp_res, exp_busy}) begin
                bad++;
                $display("FAIL random step %0d: got ov=%b res=%h busy=%b want ov=%b res=%h busy=%b",
                         i, out_valid, result, busy, exp_ov, exp_res, exp_busy);
            end
        end
        total++;
        if (pulses < 20) begin
            bad++;
            $display("FAIL random_pulses: got %0d pulses want at least 20", pulses);
        end
    endtask

    initial begin
        #23 rst_n = 1'b1;
        #1;
        test_reset();
        test_full_window(8'hFF, 1'b0, 7'd32);
        test_full_window(8'hFF, 1'b1, 7'b0100000);
        test_full_window(8'h00, 1'b1, 7'b1100000);
        test_full_window(8'h00, 1'b0, 7'd0);
        test_gaps(1'b0, 7'd16);
        test_gaps(1'b1, 7'd0);
        test_back_to_back();
        test_clear();
        test_reset_mid();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
